// File: rtl/dtt_crossbar_sched_pkg.sv
// Shared types and default sizing for the crossbar scheduler slice.
package dtt_xbar_pkg;

    localparam int N_IN_DEF       = 4;
    localparam int N_OUT_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic {
        IN_IDLE,
        IN_BUSY
    } in_state_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dtt_crossbar_sched_if.sv
// Request and crossbar-drive bundle between a requester/crossbar and the scheduler.
interface dtt_crossbar_sched_if
    import dtt_xbar_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int N_OUT      = N_OUT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] req_data      [N_IN];
    logic [N_OUT-1:0]      req_dest      [N_IN];
    logic                  req_valid     [N_IN];
    logic                  req_ready     [N_IN];
    logic                  out_ready     [N_OUT];
    logic [DATA_WIDTH-1:0] xb_data       [N_IN];
    logic [N_OUT-1:0]      xb_dest       [N_IN];
    logic                  xb_valid      [N_IN];
    logic                  zero_dest_err [N_IN];

    modport master (
        output req_data, req_dest, req_valid, out_ready,
        input  req_ready, xb_data, xb_dest, xb_valid, zero_dest_err
    );

    modport slave (
        input  req_data, req_dest, req_valid, out_ready,
        output req_ready, xb_data, xb_dest, xb_valid, zero_dest_err
    );

endinterface

// File: rtl/dtt_crossbar_sched_rr_arbiter.sv
// Round-robin arbiter for one crossbar output: first requester at or above ptr, wrapping.
module dtt_rr_arbiter
    import dtt_xbar_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    localparam int PW  = ptr_width(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic            en,
    input  logic [PW-1:0]   ptr,
    output logic [N_IN-1:0] gnt,
    output logic [PW-1:0]   ptr_next
);

    logic found;

    // Two passes: indices >= ptr first, then the wrapped lower indices.
    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (en && !found && req[i] && (i >= 32'(ptr))) begin
                gnt[i]   = 1'b1;
                found    = 1'b1;
                ptr_next = PW'((i + 1) % N_IN);
            end
        end
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (en && !found && req[i]) begin
                gnt[i]   = 1'b1;
                found    = 1'b1;
                ptr_next = PW'((i + 1) % N_IN);
            end
        end
    end

endmodule

// File: rtl/dtt_crossbar_sched.sv
// Holds one request per input and issues conflict-free, round-robin fair transfers to the crossbar.
module dtt_crossbar_sched
    import dtt_xbar_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int N_OUT      = N_OUT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    dtt_crossbar_sched_if.slave  bus
);

    localparam int PW = ptr_width(N_IN);

    in_state_e             state      [N_IN];
    in_state_e             state_next [N_IN];
    logic [N_OUT-1:0]      pend       [N_IN];
    logic [N_OUT-1:0]      pend_next  [N_IN];
    logic [DATA_WIDTH-1:0] hold       [N_IN];
    logic [DATA_WIDTH-1:0] hold_next  [N_IN];
    logic                  zde        [N_IN];
    logic                  zde_next   [N_IN];
    logic [PW-1:0]         rr_ptr     [N_OUT];
    logic [PW-1:0]         ptr_next   [N_OUT];
    logic [N_IN-1:0]       cand       [N_OUT];
    logic [N_IN-1:0]       out_gnt    [N_OUT];
    logic [N_OUT-1:0]      grant      [N_IN];

    always_comb begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
            cand[j] = '0;
            for (int unsigned i = 0; i < N_IN; i++) begin
                cand[j][i] = (state[i] == IN_BUSY) && pend[i][j];
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_arb
        dtt_rr_arbiter #(
            .N_IN (N_IN)
        ) u_arb (
            .req      (cand[j]),
            .en       (bus.out_ready[j]),
            .ptr      (rr_ptr[j]),
            .gnt      (out_gnt[j]),
            .ptr_next (ptr_next[j])
        );
    end

    // Per-output one-hot grants transposed into per-input destination subsets.
    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            grant[i] = '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                grant[i][j] = out_gnt[j][i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            bus.xb_valid[i]      = |grant[i];
            bus.xb_dest[i]       = grant[i];
            bus.xb_data[i]       = hold[i];
            bus.req_ready[i]     = (state[i] == IN_IDLE);
            bus.zero_dest_err[i] = zde[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            state_next[i] = state[i];
            pend_next[i]  = pend[i];
            hold_next[i]  = hold[i];
            zde_next[i]   = 1'b0;
            case (state[i])
                IN_IDLE: begin
                    if (bus.req_valid[i]) begin
                        hold_next[i] = bus.req_data[i];
                        pend_next[i] = bus.req_dest[i];
                        // An empty mask is flagged and dropped without ever going BUSY.
                        if (bus.req_dest[i] == '0) begin
                            zde_next[i] = 1'b1;
                        end else begin
                            state_next[i] = IN_BUSY;
                        end
                    end
                end
                IN_BUSY: begin
                    pend_next[i] = pend[i] & ~grant[i];
                    if (pend_next[i] == '0) begin
                        state_next[i] = IN_IDLE;
                    end
                end
                default: state_next[i] = IN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                state[i] <= IN_IDLE;
                pend[i]  <= '0;
                hold[i]  <= '0;
                zde[i]   <= 1'b0;
            end
            for (int unsigned j = 0; j < N_OUT; j++) begin
                rr_ptr[j] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                state[i] <= state_next[i];
                pend[i]  <= pend_next[i];
                hold[i]  <= hold_next[i];
                zde[i]   <= zde_next[i];
            end
            for (int unsigned j = 0; j < N_OUT; j++) begin
                rr_ptr[j] <= ptr_next[j];
            end
        end
    end

endmodule

// File: tb/tb_dtt_crossbar_sched.sv
// Directed bench for dtt_crossbar_sched with a per-cycle reference model and literal spot checks.
module tb_dtt_crossbar_sched;
    import dtt_xbar_pkg::*;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int DW = 32;

    typedef logic [NI-1:0][NO-1:0] gmat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dtt_crossbar_sched_if #(.N_IN(NI), .N_OUT(NO), .DATA_WIDTH(DW)) bus ();

    dtt_crossbar_sched #(
        .N_IN       (NI),
        .N_OUT      (NO),
        .DATA_WIDTH (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: what each input still owes and where each output's search starts.
    bit              m_busy [NI];
    logic [NO-1:0]   m_pend [NI];
    logic [DW-1:0]   m_hold [NI];
    bit              m_zde  [NI];
    int              m_ptr  [NO];

    // Winner for an output is the busy requester with the smallest cyclic distance from its pointer.
    function automatic gmat_t model_grants();
        gmat_t g = '0;
        for (int j = 0; j < NO; j++) begin
            if (bus.out_ready[j]) begin
                int best  = -1;
                int bestd = NI;
                for (int i = 0; i < NI; i++) begin
                    if (m_busy[i] && m_pend[i][j]) begin
                        int d = (i - m_ptr[j] + NI) % NI;
                        if (d < bestd) begin
                            bestd = d;
                            best  = i;
                        end
                    end
                end
                if (best >= 0) g[best][j] = 1'b1;
            end
        end
        return g;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_busy[i] = 1'b0;
                m_pend[i] = '0;
                m_hold[i] = '0;
                m_zde[i]  = 1'b0;
            end
            for (int j = 0; j < NO; j++) m_ptr[j] = 0;
        end else begin
            gmat_t g;
            g = model_grants();
            for (int j = 0; j < NO; j++) begin
                for (int i = 0; i < NI; i++) begin
                    if (g[i][j]) m_ptr[j] = (i + 1) % NI;
                end
            end
            for (int i = 0; i < NI; i++) begin
                m_zde[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (bus.req_valid[i]) begin
                        m_hold[i] = bus.req_data[i];
                        m_pend[i] = bus.req_dest[i];
                        m_busy[i] = (bus.req_dest[i] != '0);
                        m_zde[i]  = (bus.req_dest[i] == '0);
                    end
                end else begin
                    m_pend[i] = m_pend[i] & ~g[i];
                    if (m_pend[i] == '0) m_busy[i] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, req);
        end
    endtask

    always @(negedge clk) begin
        gmat_t g;
        g = model_grants();
        for (int i = 0; i < NI; i++) begin
            chk("m_xb_valid", i, 64'(bus.xb_valid[i]), 64'(|g[i]));
            chk("m_xb_dest", i, 64'(bus.xb_dest[i]), 64'(g[i]));
            chk("m_xb_data", i, 64'(bus.xb_data[i]), 64'(m_hold[i]));
            chk("m_req_ready", i, 64'(bus.req_ready[i]), 64'(!m_busy[i]));
            chk("m_zero_dest_err", i, 64'(bus.zero_dest_err[i]), 64'(m_zde[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [DW-1:0] d, input logic [NO-1:0] dest);
        bus.req_data[i]  = d;
        bus.req_dest[i]  = dest;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic clr();
        for (int i = 0; i < NI; i++) bus.req_valid[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            bus.req_data[i]  = '0;
            bus.req_dest[i]  = '0;
            bus.req_valid[i] = 1'b0;
        end
        for (int j = 0; j < NO; j++) bus.out_ready[j] = 1'b1;

        // Reset
        #12;
        for (int i = 0; i < NI; i++) begin
            chk("rst_xb_valid", i, 64'(bus.xb_valid[i]), 64'h0);
            chk("rst_xb_dest", i, 64'(bus.xb_dest[i]), 64'h0);
        end
        #8 rst = 1'b0;
        #2;
        for (int i = 0; i < NI; i++) chk("rst_req_ready", i, 64'(bus.req_ready[i]), 64'h1);
        tick();

        // Contention on output 2
        put(0, 32'hAAAABBBB, 4'b0100);
        put(1, 32'hCCCCDDDD, 4'b0100);
        tick();
        clr();
        @(negedge clk);
        chk("cont_k1_valid0", 0, 64'(bus.xb_valid[0]), 64'h1);
        chk("cont_k1_dest0", 0, 64'(bus.xb_dest[0]), 64'h4);
        chk("cont_k1_data0", 0, 64'(bus.xb_data[0]), 64'hAAAABBBB);
        chk("cont_k1_valid1", 1, 64'(bus.xb_valid[1]), 64'h0);
        tick();
        @(negedge clk);
        chk("cont_k2_valid1", 1, 64'(bus.xb_valid[1]), 64'h1);
        chk("cont_k2_data1", 1, 64'(bus.xb_data[1]), 64'hCCCCDDDD);
        chk("cont_k2_ready0", 0, 64'(bus.req_ready[0]), 64'h1);
        tick();

        // Multicast without conflict
        put(3, 32'h11112222, 4'b1010);
        tick();
        clr();
        @(negedge clk);
        chk("mc_valid3", 3, 64'(bus.xb_valid[3]), 64'h1);
        chk("mc_dest3", 3, 64'(bus.xb_dest[3]), 64'hA);
        tick();
        @(negedge clk);
        chk("mc_ready3", 3, 64'(bus.req_ready[3]), 64'h1);
        chk("mc_done3", 3, 64'(bus.xb_valid[3]), 64'h0);
        tick();

        // Partial multicast
        put(0, 32'h00000A0A, 4'b0011);
        put(2, 32'h00000C0C, 4'b0010);
        tick();
        clr();
        @(negedge clk);
        chk("pm_k1_dest0", 0, 64'(bus.xb_dest[0]), 64'h3);
        chk("pm_k1_valid2", 2, 64'(bus.xb_valid[2]), 64'h0);
        tick();
        @(negedge clk);
        chk("pm_k2_valid2", 2, 64'(bus.xb_valid[2]), 64'h1);
        chk("pm_k2_dest2", 2, 64'(bus.xb_dest[2]), 64'h2);
        tick();

        // Backpressure on output 2
        bus.out_ready[2] = 1'b0;
        put(0, 32'h0BADF00D, 4'b0100);
        tick();
        clr();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("bp_hold_valid0", n, 64'(bus.xb_valid[0]), 64'h0);
            tick();
        end
        bus.out_ready[2] = 1'b1;
        @(negedge clk);
        chk("bp_rise_valid0", 0, 64'(bus.xb_valid[0]), 64'h1);
        chk("bp_rise_dest0", 0, 64'(bus.xb_dest[0]), 64'h4);
        tick();

        // Zero destination
        put(1, 32'h5A5A5A5A, 4'b0000);
        tick();
        clr();
        @(negedge clk);
        chk("zd_err1", 1, 64'(bus.zero_dest_err[1]), 64'h1);
        chk("zd_valid1", 1, 64'(bus.xb_valid[1]), 64'h0);
        tick();
        @(negedge clk);
        chk("zd_err1_end", 1, 64'(bus.zero_dest_err[1]), 64'h0);
        tick();

        // Reset mid-multicast: output 1 stalled so in0 stays BUSY with a bit pending
        bus.out_ready[1] = 1'b0;
        put(0, 32'h77778888, 4'b0011);
        tick();
        clr();
        @(negedge clk);
        chk("mr_pre_dest0", 0, 64'(bus.xb_dest[0]), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("mr_async_valid0", 0, 64'(bus.xb_valid[0]), 64'h0);
        chk("mr_async_dest0", 0, 64'(bus.xb_dest[0]), 64'h0);
        chk("mr_async_data0", 0, 64'(bus.xb_data[0]), 64'h0);
        bus.out_ready[1] = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk("mr_after_valid0", n, 64'(bus.xb_valid[0]), 64'h0);
            chk("mr_after_ready0", n, 64'(bus.req_ready[0]), 64'h1);
        end
        tick();

        // All inputs on output 0: served 0,1,2,3 and pointer wraps
        for (int i = 0; i < NI; i++) put(i, 32'hF0000000 | 32'(i), 4'b0001);
        tick();
        clr();
        for (int n = 0; n < NI; n++) begin
            @(negedge clk);
            chk("rr_winner_valid", n, 64'(bus.xb_valid[n]), 64'h1);
            chk("rr_winner_dest", n, 64'(bus.xb_dest[n]), 64'h1);
            tick();
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk("rr_end_ready", i, 64'(bus.req_ready[i]), 64'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dtt_crossbar_sched.md
# dtt_crossbar_sched

Round-robin scheduler sitting in front of `dtt_crossbar_switch`. It accepts one request per input port (data plus destination bitmask) through a valid/ready handshake and holds it. Each cycle it issues a conflict-free set of input-to-output transfers to the crossbar, so no output is driven by two inputs at once. Multicast requests may be served across several cycles, and per-output round-robin pointers guarantee fairness.

## Interface
**Parameters**
- `N_IN`, 4: number of input ports.
- `N_OUT`, 4: number of output ports; also the width of the destination bitmask.
- `DATA_WIDTH`, 32: payload width.

**Ports**
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_data[N_IN]`  in  DATA_WIDTH: request payload.
- `req_dest[N_IN]`  in  N_OUT: destination bitmask; bit j set means deliver to output j.
- `req_valid[N_IN]`  in  1: request present.
- `req_ready[N_IN]`  out  1: scheduler can accept a request on this input.
- `out_ready[N_OUT]`  in  1: output j may be granted this cycle.
- `xb_data[N_IN]`  out  DATA_WIDTH: drives crossbar `in_data`.
- `xb_dest[N_IN]`  out  N_OUT: drives crossbar `in_dest`; holds the granted subset only.
- `xb_valid[N_IN]`  out  1: drives crossbar `in_valid`.
- `zero_dest_err[N_IN]`  out  1: one-cycle pulse when a request with an all-zero `req_dest` is accepted.

## Operation
- **Per-input FSM, IDLE → BUSY.**
  - IDLE: `req_ready`=1. If `req_valid` is high, capture `req_data` into `hold[i]` and `req_dest` into `pend[i]`, then go to BUSY.
  - If the captured `req_dest` is 0, stay IDLE, pulse `zero_dest_err[i]` on the next cycle and issue nothing.
  - BUSY: `req_ready`=0.
- **Per-output arbitration, every cycle.**
  - Candidates for output j are all inputs in BUSY with `pend[i][j]`=1.
  - If `out_ready[j]`=1 and at least one candidate exists, grant the first candidate found searching upward from `rr_ptr[j]`, wrapping modulo N_IN.
  - `grant[i]` is the OR of the one-hot output grants for input i.
- **Crossbar outputs**, combinational from registered state, `out_ready` and the grant logic:
  - `xb_valid[i]` = |`grant[i]`
  - `xb_dest[i]` = `grant[i]`
  - `xb_data[i]` = `hold[i]`
- **Update at the clock edge.**
  - `pend[i]` <= `pend[i]` & ~`grant[i]`.
  - If the result is 0, the input returns to IDLE.
  - `rr_ptr[j]` <= (winner+1) mod N_IN on a grant; otherwise it is unchanged.
- **Multicast.** All granted bits of one input are issued in the same cycle. Remaining bits retry on later cycles with the same `hold` data.
- **Fairness.** A BUSY input waits at most N_IN-1 grants of a given output before it is served, provided `out_ready` is eventually high.

## Timing
- **Reset values, while `rst` is high:**
  - All inputs IDLE; `pend`=0, `hold`=0, `rr_ptr`=0.
  - `xb_valid`=0, `xb_dest`=0, `xb_data`=0, `zero_dest_err`=0.
  - `req_ready`=1 once `rst` is low.
- **Latency.** A request accepted at edge k appears on `xb_*` during cycle k+1 at the earliest.
- **Throughput.** One request per input every 2 cycles at best, because accept and final grant cannot overlap.
- **`out_ready`.** Sampled combinationally in the same cycle as the grant it gates.
- **Simultaneous requests.** All inputs may accept on the same edge. Conflicts are resolved on the following cycles by `rr_ptr`.
- **Wrap-around.** `rr_ptr` moves from N_IN-1 to 0.
- **Reset mid-operation.** All pending transfers are dropped immediately (asynchronously). `xb_valid` falls without waiting for a clock edge, and no partial multicast resumes after reset.

## Structure
- **Package `dtt_xbar_pkg`:**
  - In-state enum: `IN_IDLE`, `IN_BUSY`.
  - Default parameter constants `N_IN_DEF`, `N_OUT_DEF`, `DATA_WIDTH_DEF`.
- **Sub-module `dtt_rr_arbiter`:**
  - Parameter N_IN.
  - Inputs: request vector, enable, pointer.
  - Outputs: one-hot grant and next pointer.
  - Instantiated once per output.

## Test plan
1. **Reset.** Hold `rst` high for 20 ns.
   - Expect `xb_valid` all 0 and `xb_dest` all 0.
   - After release, expect `req_ready` all 1.
2. **Contention.** in0 = AAAABBBB and in1 = CCCCDDDD, both with dest 4'b0100, accepted on the same edge.
   - Cycle k+1: `xb_valid[0]`=1, `xb_dest[0]`=0100, `xb_valid[1]`=0.
   - Cycle k+2: `xb_valid[1]`=1 with data CCCCDDDD; `req_ready[0]`=1.
3. **Multicast without conflict.** in3 = 11112222 with dest 4'b1010.
   - Single cycle with `xb_dest[3]`=1010.
   - `req_ready[3]`=1 on the next cycle.
4. **Partial multicast.** in0 with dest 0011 and in2 with dest 0010, accepted on the same edge, `rr_ptr` at 0.
   - Cycle k+1: in0 granted 0011; in2 gets nothing.
   - Cycle k+2: in2 granted 0010.
5. **Backpressure.** `out_ready[2]`=0 for 3 cycles while in0 holds dest 0100.
   - `xb_valid[0]`=0 for those cycles.
   - Grant is issued in the cycle `out_ready[2]` rises.
6. **Zero-dest and reset mid-operation.**
   - in1 with dest 0000: `zero_dest_err[1]` pulses for exactly 1 cycle and no `xb_valid[1]`.
   - Assert `rst` while in0 is BUSY: `xb_valid[0]` goes to 0 immediately, and stays 0 after release.
